// File: rtl/multi_zone_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// multi_zone_alarm_ctrl
//
// Purpose
//   Multi-zone tripwire alarm controller. Arms and disarms NUM_ZONES laser
//   zones with an exit (arming) delay, an entry delay, an alert timeout that
//   automatically re-arms, a wrong-code attempt limit and a lockout period.
//   It sits between the ADC/laser front ends plus the passcode checker and
//   the 7-seg / VGA / LED display blocks.
//
// Optional feature
//   ZONE_DEBOUNCE_EN : when defined, each synchronised zone input must hold a
//   new value for DEBOUNCE_CYC consecutive cycles before its debounced bit
//   follows. When undefined, zones are used raw after a 2-flop synchroniser.
//
// Ports
//   clock          in   1          system clock, rising edge
//   rst            in   1          synchronous reset, active-low
//   arm_req        in   1          1-cycle pulse: request arming
//   zone_trip      in   NUM_ZONES  1 = beam broken in that zone (level)
//   zone_enable    in   NUM_ZONES  1 = zone monitored
//   code_valid     in   1          1-cycle pulse: passcode entry complete
//   code_ok        in   1          qualifies code_valid: 1 = correct code
//   system_state   out  3          0 IDLE,1 ARMING,2 ARMED,3 TRIGGER,4 ALERT,5 LOCKOUT
//   seconds_timer  out  TIMER_W    remaining seconds in a timed state, else 0
//   tripped_zones  out  NUM_ZONES  sticky record of zones tripped this incident
//   attempts_left  out  3          remaining wrong-code allowance
//   alarm_out      out  1          1 in ALERT and LOCKOUT
//   arm_fault      out  1          1-cycle pulse: arming refused
// -----------------------------------------------------------------------------
module multi_zone_alarm_ctrl #(
    parameter int NUM_ZONES       = 4,
    parameter int CLK_HZ          = 50_000_000,
    parameter int TIMER_W         = 8,
    parameter int ARM_DELAY_S     = 10,
    parameter int ENTRY_DELAY_S   = 15,
    parameter int ALERT_TIMEOUT_S = 60,
    parameter int LOCKOUT_S       = 30,
    parameter int MAX_ATTEMPTS    = 3,
    parameter int DEBOUNCE_CYC    = 1000
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 arm_req,
    input  logic [NUM_ZONES-1:0] zone_trip,
    input  logic [NUM_ZONES-1:0] zone_enable,
    input  logic                 code_valid,
    input  logic                 code_ok,
    output logic [2:0]           system_state,
    output logic [TIMER_W-1:0]   seconds_timer,
    output logic [NUM_ZONES-1:0] tripped_zones,
    output logic [2:0]           attempts_left,
    output logic                 alarm_out,
    output logic                 arm_fault
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMING  = 3'd1,
        S_ARMED   = 3'd2,
        S_TRIGGER = 3'd3,
        S_ALERT   = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    localparam int                 PRE_W   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0]   PRE_MAX = PRE_W'(CLK_HZ - 1);
    localparam logic [2:0]         ATT_MAX = 3'(MAX_ATTEMPTS);
    localparam logic [TIMER_W-1:0] T_ARM   = TIMER_W'(ARM_DELAY_S);
    localparam logic [TIMER_W-1:0] T_ENTRY = TIMER_W'(ENTRY_DELAY_S);
    localparam logic [TIMER_W-1:0] T_ALERT = TIMER_W'(ALERT_TIMEOUT_S);
    localparam logic [TIMER_W-1:0] T_LOCK  = TIMER_W'(LOCKOUT_S);
    localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);

    // ---------------------------------------------------------------------
    // Zone input conditioning: 2-flop synchroniser (p0 -> p1)
    // ---------------------------------------------------------------------
    logic [NUM_ZONES-1:0] zone_sync_p0;
    logic [NUM_ZONES-1:0] zone_sync_p1;
    logic [NUM_ZONES-1:0] zone_db;
    logic [NUM_ZONES-1:0] act;

    always_ff @(posedge clock) begin
        if (!rst) begin
            zone_sync_p0 <= '0;
            zone_sync_p1 <= '0;
        end else begin
            zone_sync_p0 <= zone_trip;
            zone_sync_p1 <= zone_sync_p0;
        end
    end

`ifdef ZONE_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYC - 1);

    logic [DEB_W-1:0] deb_cnt [NUM_ZONES];

    // The counter only runs while the synchronised input disagrees with the
    // debounced bit; any return to agreement restarts the count.
    always_ff @(posedge clock) begin
        if (!rst) begin
            zone_db <= '0;
            for (int z = 0; z < NUM_ZONES; z++) begin
                deb_cnt[z] <= '0;
            end
        end else begin
            for (int z = 0; z < NUM_ZONES; z++) begin
                if (zone_sync_p1[z] != zone_db[z]) begin
                    if (deb_cnt[z] == DEB_LAST) begin
                        zone_db[z] <= zone_sync_p1[z];
                        deb_cnt[z] <= '0;
                    end else begin
                        deb_cnt[z] <= deb_cnt[z] + 1'b1;
                    end
                end else begin
                    deb_cnt[z] <= '0;
                end
            end
        end
    end
`else
    assign zone_db = zone_sync_p1;
`endif

    assign act = zone_db & zone_enable;

    // ---------------------------------------------------------------------
    // Control state
    // ---------------------------------------------------------------------
    state_t               state_q, state_nx;
    logic [PRE_W-1:0]     presc_q, presc_nx;
    logic [TIMER_W-1:0]   timer_q, timer_nx;
    logic [NUM_ZONES-1:0] tripped_q, tripped_nx;
    logic [2:0]           attempts_q, attempts_nx;
    logic                 alarm_q, alarm_nx;
    logic                 arm_fault_q, arm_fault_nx;

    logic       tick;
    logic       expiry;
    logic       code_good;
    logic       code_bad;
    logic [2:0] att_dec;

    assign tick      = (presc_q == PRE_MAX);
    // Timed states count N..1, so the last second ends on a tick at 1.
    assign expiry    = tick && (timer_q == T_ONE);
    assign code_good = code_valid && code_ok;
    assign code_bad  = code_valid && !code_ok;
    assign att_dec   = (attempts_q == 3'd0) ? 3'd0 : attempts_q - 3'd1;

    // State register
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            timer_q     <= '0;
            tripped_q   <= '0;
            attempts_q  <= ATT_MAX;
            alarm_q     <= 1'b0;
            arm_fault_q <= 1'b0;
        end else begin
            state_q     <= state_nx;
            presc_q     <= presc_nx;
            timer_q     <= timer_nx;
            tripped_q   <= tripped_nx;
            attempts_q  <= attempts_nx;
            alarm_q     <= alarm_nx;
            arm_fault_q <= arm_fault_nx;
        end
    end

    // Next-state logic. Code events are tested before expiry and zone
    // activity so they win any same-cycle collision.
    always_comb begin
        state_nx    = state_q;
        tripped_nx  = tripped_q;
        attempts_nx = attempts_q;
        presc_nx    = presc_q;
        timer_nx    = timer_q;

        case (state_q)
            S_IDLE: begin
                if (arm_req && (act == '0)) begin
                    state_nx = S_ARMING;
                end
            end
            S_ARMING: begin
                if (code_good) begin
                    state_nx = S_IDLE;
                end else if (expiry) begin
                    state_nx = S_ARMED;
                end
            end
            S_ARMED: begin
                if (code_good) begin
                    state_nx = S_IDLE;
                end else if (act != '0) begin
                    state_nx    = S_TRIGGER;
                    tripped_nx  = tripped_q | act;
                    attempts_nx = ATT_MAX;
                end
            end
            S_TRIGGER: begin
                tripped_nx = tripped_q | act;
                if (code_good) begin
                    state_nx = S_IDLE;
                end else if (code_bad) begin
                    attempts_nx = att_dec;
                    if (att_dec == 3'd0) begin
                        state_nx = S_ALERT;
                    end
                end else if (expiry) begin
                    state_nx = S_ALERT;
                end
            end
            S_ALERT: begin
                tripped_nx = tripped_q | act;
                if (code_good) begin
                    state_nx = S_IDLE;
                end else if (code_bad) begin
                    attempts_nx = att_dec;
                    if (att_dec == 3'd0) begin
                        state_nx = S_LOCKOUT;
                    end
                end else if (expiry) begin
                    // Silence and re-arm; the incident record is kept.
                    state_nx    = S_ARMED;
                    attempts_nx = ATT_MAX;
                end
            end
            S_LOCKOUT: begin
                tripped_nx = tripped_q | act;
                if (expiry) begin
                    state_nx    = S_ALERT;
                    attempts_nx = ATT_MAX;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (state_nx == S_IDLE) begin
            tripped_nx  = '0;
            attempts_nx = ATT_MAX;
        end

        // Restarting the prescaler on every state change makes the first
        // decrement land exactly CLK_HZ cycles after entry.
        if (state_nx != state_q) begin
            presc_nx = '0;
            case (state_nx)
                S_ARMING:  timer_nx = T_ARM;
                S_TRIGGER: timer_nx = T_ENTRY;
                S_ALERT:   timer_nx = T_ALERT;
                S_LOCKOUT: timer_nx = T_LOCK;
                default:   timer_nx = '0;
            endcase
        end else begin
            presc_nx = tick ? '0 : presc_q + 1'b1;
            if (tick && (timer_q != '0)) begin
                timer_nx = timer_q - T_ONE;
            end
        end
    end

    // Output logic (registered in the state register process)
    always_comb begin
        alarm_nx     = (state_nx == S_ALERT) || (state_nx == S_LOCKOUT);
        arm_fault_nx = (state_q == S_IDLE) && arm_req && (act != '0);
    end

    assign system_state  = state_q;
    assign seconds_timer = timer_q;
    assign tripped_zones = tripped_q;
    assign attempts_left = attempts_q;
    assign alarm_out     = alarm_q;
    assign arm_fault     = arm_fault_q;

endmodule

// File: tb/tb_multi_zone_alarm_ctrl.sv
module tb_multi_zone_alarm_ctrl;

    localparam int NZ    = 4;
    localparam int CLKHZ = 10;
    localparam int TW    = 8;
    localparam int ARM_S = 3;
    localparam int ENT_S = 4;
    localparam int ALR_S = 5;
    localparam int LCK_S = 2;
    localparam int MAXA  = 2;
    localparam int DEB   = 4;

    logic          clock;
    logic          rst;
    logic          arm_req;
    logic [NZ-1:0] zone_trip;
    logic [NZ-1:0] zone_enable;
    logic          code_valid;
    logic          code_ok;
    logic [2:0]    system_state;
    logic [TW-1:0] seconds_timer;
    logic [NZ-1:0] tripped_zones;
    logic [2:0]    attempts_left;
    logic          alarm_out;
    logic          arm_fault;

    multi_zone_alarm_ctrl #(
        .NUM_ZONES(NZ), .CLK_HZ(CLKHZ), .TIMER_W(TW),
        .ARM_DELAY_S(ARM_S), .ENTRY_DELAY_S(ENT_S), .ALERT_TIMEOUT_S(ALR_S),
        .LOCKOUT_S(LCK_S), .MAX_ATTEMPTS(MAXA), .DEBOUNCE_CYC(DEB)
    ) dut (
        .clock(clock), .rst(rst), .arm_req(arm_req), .zone_trip(zone_trip),
        .zone_enable(zone_enable), .code_valid(code_valid), .code_ok(code_ok),
        .system_state(system_state), .seconds_timer(seconds_timer),
        .tripped_zones(tripped_zones), .attempts_left(attempts_left),
        .alarm_out(alarm_out), .arm_fault(arm_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    // ---------------- reference model (time-in-state view) ----------------
    int            m_st;
    int            m_age;
    logic [NZ-1:0] m_tz;
    int            m_att;
    bit            m_al;
    bit            m_fa;
    logic [NZ-1:0] m_h0, m_h1, m_db;
    int            m_run [NZ];

    function automatic int load_of(int s);
        case (s)
            1: return ARM_S;
            3: return ENT_S;
            4: return ALR_S;
            5: return LCK_S;
            default: return 0;
        endcase
    endfunction

    function automatic int m_timer();
        if (load_of(m_st) == 0) return 0;
        return load_of(m_st) - m_age / CLKHZ;
    endfunction

    task automatic model_step();
        logic [NZ-1:0] a;
        int nxt;
        bit good, bad, expd;
        if (!rst) begin
            m_st = 0; m_age = 0; m_tz = '0; m_att = MAXA; m_al = 0; m_fa = 0;
            m_h0 = '0; m_h1 = '0; m_db = '0;
            for (int z = 0; z < NZ; z++) m_run[z] = 0;
            return;
        end
`ifdef ZONE_DEBOUNCE_EN
        a = m_db & zone_enable;
`else
        a = m_h1 & zone_enable;
`endif
        good = code_valid && code_ok;
        bad  = code_valid && !code_ok;
        expd = (load_of(m_st) != 0) && (m_age + 1 == load_of(m_st) * CLKHZ);
        m_fa = (m_st == 0) && arm_req && (a != '0);
        nxt  = m_st;
        case (m_st)
            0: if (arm_req && a == '0) nxt = 1;
            1: if (good) nxt = 0; else if (expd) nxt = 2;
            2: if (good) nxt = 0;
               else if (a != '0) begin nxt = 3; m_tz = m_tz | a; m_att = MAXA; end
            3: begin
                m_tz = m_tz | a;
                if (good) nxt = 0;
                else if (bad) begin m_att = m_att - 1; if (m_att == 0) nxt = 4; end
                else if (expd) nxt = 4;
            end
            4: begin
                m_tz = m_tz | a;
                if (good) nxt = 0;
                else if (bad) begin
                    if (m_att > 0) m_att = m_att - 1;
                    if (m_att == 0) nxt = 5;
                end else if (expd) begin nxt = 2; m_att = MAXA; end
            end
            default: begin
                m_tz = m_tz | a;
                if (expd) begin nxt = 4; m_att = MAXA; end
            end
        endcase
        if (nxt == 0) begin m_tz = '0; m_att = MAXA; end
        m_age = (nxt != m_st) ? 0 : m_age + 1;
        m_st  = nxt;
        m_al  = (nxt == 4) || (nxt == 5);
        for (int z = 0; z < NZ; z++) begin
            if (m_h1[z] != m_db[z]) begin
                m_run[z]++;
                if (m_run[z] == DEB) begin m_db[z] = m_h1[z]; m_run[z] = 0; end
            end else begin
                m_run[z] = 0;
            end
        end
        m_h1 = m_h0;
        m_h0 = zone_trip;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int         n;
        bit         r, arm;
        logic [3:0] trip, en;
        bit         cv, ok;
        int         st, tm;
        logic [3:0] tz;
        int         att;
        bit         al, fa;
    } vec_t;

    vec_t tbl [$];

    initial begin
        rst = 1'b0; arm_req = 1'b0; zone_trip = '0; zone_enable = '1;
        code_valid = 1'b0; code_ok = 1'b0;

        //                n  r arm trip  en   cv ok  st tm tz   att al fa
        tbl.push_back('{ 2, 0, 0, 4'h0, 4'hF, 0, 0,  0, 0, 4'h0, 2, 0, 0}); // reset
        tbl.push_back('{ 1, 1, 1, 4'h0, 4'hF, 0, 0,  1, 3, 4'h0, 2, 0, 0}); // arm
        tbl.push_back('{ 9, 1, 0, 4'h0, 4'hF, 0, 0,  1, 3, 4'h0, 2, 0, 0});
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 0, 0,  1, 2, 4'h0, 2, 0, 0});
        tbl.push_back('{19, 1, 0, 4'h0, 4'hF, 0, 0,  1, 1, 4'h0, 2, 0, 0});
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 0, 0,  2, 0, 4'h0, 2, 0, 0}); // ARMED @30
        tbl.push_back('{ 1, 1, 1, 4'h0, 4'hF, 0, 0,  2, 0, 4'h0, 2, 0, 0}); // arm_req ignored
        tbl.push_back('{ 1, 1, 0, 4'h4, 4'hF, 0, 0,  2, 0, 4'h0, 2, 0, 0}); // sync latency
        tbl.push_back('{ 2, 1, 0, 4'h4, 4'hF, 0, 0,  3, 4, 4'h4, 2, 0, 0}); // TRIGGER
        tbl.push_back('{39, 1, 0, 4'h0, 4'hF, 0, 0,  3, 1, 4'h4, 2, 0, 0});
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 0, 0,  4, 5, 4'h4, 2, 1, 0}); // ALERT
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 1, 1,  0, 0, 4'h0, 2, 0, 0}); // disarm
        tbl.push_back('{ 2, 1, 0, 4'h1, 4'h1, 0, 0,  0, 0, 4'h0, 2, 0, 0});
        tbl.push_back('{ 1, 1, 1, 4'h1, 4'h1, 0, 0,  0, 0, 4'h0, 2, 0, 1}); // arm_fault
        tbl.push_back('{ 1, 1, 0, 4'h1, 4'h1, 0, 0,  0, 0, 4'h0, 2, 0, 0});
        tbl.push_back('{ 1, 1, 1, 4'h1, 4'h0, 0, 0,  1, 3, 4'h0, 2, 0, 0}); // masked arms
        tbl.push_back('{ 1, 1, 0, 4'h1, 4'h0, 1, 1,  0, 0, 4'h0, 2, 0, 0}); // abort arming
        tbl.push_back('{ 2, 1, 0, 4'h0, 4'hF, 0, 0,  0, 0, 4'h0, 2, 0, 0});
        tbl.push_back('{ 1, 1, 1, 4'h0, 4'hF, 0, 0,  1, 3, 4'h0, 2, 0, 0});
        tbl.push_back('{30, 1, 0, 4'h0, 4'hF, 0, 0,  2, 0, 4'h0, 2, 0, 0});
        tbl.push_back('{ 3, 1, 0, 4'h8, 4'hF, 0, 0,  3, 4, 4'h8, 2, 0, 0});
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 1, 0,  3, 4, 4'h8, 1, 0, 0}); // wrong #1
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 1, 0,  4, 5, 4'h8, 0, 1, 0}); // wrong #2
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 1, 0,  5, 2, 4'h8, 0, 1, 0}); // LOCKOUT
        tbl.push_back('{19, 1, 0, 4'h0, 4'hF, 1, 1,  5, 1, 4'h8, 0, 1, 0}); // code ignored
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 0, 0,  4, 5, 4'h8, 2, 1, 0});
        tbl.push_back('{49, 1, 0, 4'h0, 4'hF, 0, 0,  4, 1, 4'h8, 2, 1, 0});
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 0, 0,  2, 0, 4'h8, 2, 0, 0}); // re-arm
        tbl.push_back('{ 3, 1, 0, 4'h2, 4'hF, 0, 0,  3, 4, 4'hA, 2, 0, 0}); // sticky
        tbl.push_back('{39, 1, 0, 4'h0, 4'hF, 0, 0,  3, 1, 4'hA, 2, 0, 0});
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 1, 1,  0, 0, 4'h0, 2, 0, 0}); // code beats expiry
        tbl.push_back('{ 1, 1, 1, 4'h0, 4'hF, 0, 0,  1, 3, 4'h0, 2, 0, 0});
        tbl.push_back('{30, 1, 0, 4'h0, 4'hF, 0, 0,  2, 0, 4'h0, 2, 0, 0});
        tbl.push_back('{ 3, 1, 0, 4'h1, 4'hF, 0, 0,  3, 4, 4'h1, 2, 0, 0});
        tbl.push_back('{ 2, 1, 0, 4'h0, 4'hF, 1, 0,  4, 5, 4'h1, 0, 1, 0});
        tbl.push_back('{ 1, 0, 0, 4'h0, 4'hF, 0, 0,  0, 0, 4'h0, 2, 0, 0}); // reset in ALERT
        tbl.push_back('{ 1, 1, 0, 4'h0, 4'hF, 0, 0,  0, 0, 4'h0, 2, 0, 0});

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; arm_req = tbl[i].arm; zone_trip = tbl[i].trip;
            zone_enable = tbl[i].en; code_valid = tbl[i].cv; code_ok = tbl[i].ok;
            for (int k = 0; k < tbl[i].n; k++) tick();
            chk($sformatf("v%0d.state", i), 32'(system_state),  32'(tbl[i].st));
            chk($sformatf("v%0d.timer", i), 32'(seconds_timer), 32'(tbl[i].tm));
            chk($sformatf("v%0d.zones", i), 32'(tripped_zones), 32'(tbl[i].tz));
            chk($sformatf("v%0d.att", i),   32'(attempts_left), 32'(tbl[i].att));
            chk($sformatf("v%0d.alarm", i), 32'(alarm_out),     32'(tbl[i].al));
            chk($sformatf("v%0d.fault", i), 32'(arm_fault),     32'(tbl[i].fa));
        end

        // ---------------- randomized run against the model ----------------
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 399) != 0);
            arm_req    = ($urandom_range(0, 5) == 0);
            code_valid = ($urandom_range(0, 24) == 0);
            code_ok    = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) zone_trip[$urandom_range(0, NZ-1)] ^= 1'b1;
            if ($urandom_range(0, 49) == 0) zone_enable = 4'($urandom);
            tick();
            chk($sformatf("rnd%0d", c),
                32'({system_state, seconds_timer, tripped_zones, attempts_left, alarm_out, arm_fault}),
                32'({3'(m_st), TW'(m_timer()), m_tz, 3'(m_att), m_al, m_fa}));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
